// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // Load-op encoding carried from EX; 6 and 7 are treated as "no load".
  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_B    = 3'd1,
    LD_H    = 3'd2,
    LD_W    = 3'd3,
    LD_BU   = 3'd4,
    LD_HU   = 3'd5
  } load_op_e;

  localparam logic [3:0] RF_WE_ALL = 4'b1111;

  // True for the five real load encodings only.
  function automatic logic is_load_op(input logic [2:0] op);
    return (op == LD_B) || (op == LD_H) || (op == LD_W) ||
           (op == LD_BU) || (op == LD_HU);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half out of a load word and sign/zero extends it.
// Assumes a 32-bit data word (four byte lanes).
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        off_i,
  input  logic [2:0]        load_op_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select, then extension by load type. Half loads ignore off[0]
  // because upstream guarantees alignment.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (off_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (load_op_i)
      LD_B:    data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_BU:   data_o = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_H:    data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LD_HU:   data_o = {{(DATA_W-16){1'b0}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction from EX, waits for load data,
// aligns it and hands the register-file write bundle to WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = mem_stage_pkg::ADDR_W,
  parameter int DATA_W = mem_stage_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_to_mem_valid,
  output logic              mem_allow_in,
  input  logic [31:0]       ex_pc,
  input  logic              ex_rf_we,
  input  logic [ADDR_W-1:0] ex_rf_waddr,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [2:0]        ex_load_op,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic              to_wb_valid,
  input  logic              wb_allow_in,
  output logic [31:0]       wb_pc,
  output logic [3:0]        wb_rf_we,
  output logic [ADDR_W-1:0] wb_rf_waddr,
  output logic [DATA_W-1:0] wb_rf_wdata,
  output logic              mem_fwd_we,
  output logic [ADDR_W-1:0] mem_fwd_waddr,
  output logic [DATA_W-1:0] mem_fwd_wdata,
  output logic              mem_fwd_busy
);

  logic              mem_valid_q, mem_valid_d;
  logic              data_got_q, data_got_d;
  logic [DATA_W-1:0] rdata_buf_q, rdata_buf_d;
  logic [31:0]       pc_q;
  logic              rf_we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] alu_q;
  logic [2:0]        load_op_q;

  logic              is_load, ready_go;
  logic [DATA_W-1:0] load_raw, load_aligned;

  assign is_load  = is_load_op(load_op_q);
  assign ready_go = !is_load | data_got_q | data_sram_data_ok;

  assign mem_allow_in = !mem_valid_q | (ready_go & wb_allow_in);
  assign to_wb_valid  = mem_valid_q & ready_go;

  // Once buffered, the held word wins over whatever the SRAM bus shows now.
  assign load_raw = data_got_q ? rdata_buf_q : data_sram_rdata;

  mem_load_align u_align (
    .rdata_i   (load_raw),
    .off_i     (alu_q[1:0]),
    .load_op_i (load_op_q),
    .data_o    (load_aligned)
  );

  assign wb_pc       = pc_q;
  assign wb_rf_waddr = waddr_q;
  assign wb_rf_wdata = is_load ? load_aligned : alu_q;
  assign wb_rf_we    = (mem_valid_q & rf_we_q) ? RF_WE_ALL : 4'b0000;

  assign mem_fwd_we    = mem_valid_q & rf_we_q & (waddr_q != '0);
  assign mem_fwd_waddr = waddr_q;
  assign mem_fwd_wdata = wb_rf_wdata;
  assign mem_fwd_busy  = mem_fwd_we & is_load & !ready_go;

  // Next state: advance clears the buffer flag; a load response that WB
  // cannot take yet is parked in rdata_buf. Stray data_ok is ignored.
  always_comb begin
    mem_valid_d = mem_valid_q;
    data_got_d  = data_got_q;
    rdata_buf_d = rdata_buf_q;
    if (mem_allow_in) begin
      mem_valid_d = ex_to_mem_valid;
      data_got_d  = 1'b0;
    end else if (mem_valid_q & is_load & !data_got_q & data_sram_data_ok) begin
      data_got_d  = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q <= 1'b0;
      data_got_q  <= 1'b0;
      rdata_buf_q <= '0;
      pc_q        <= '0;
      rf_we_q     <= 1'b0;
      waddr_q     <= '0;
      alu_q       <= '0;
      load_op_q   <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      data_got_q  <= data_got_d;
      rdata_buf_q <= rdata_buf_d;
      if (ex_to_mem_valid & mem_allow_in) begin
        pc_q      <= ex_pc;
        rf_we_q   <= ex_rf_we;
        waddr_q   <= ex_rf_waddr;
        alu_q     <= ex_alu_result;
        load_op_q <= ex_load_op;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver issues EX instructions and SRAM/WB
// activity; a monitor checks every cycle against a transaction-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_to_mem_valid, mem_allow_in;
  logic [31:0] ex_pc;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_alu_result;
  logic [2:0]  ex_load_op;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        to_wb_valid, wb_allow_in;
  logic [31:0] wb_pc;
  logic [3:0]  wb_rf_we;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_rf_wdata;
  logic        mem_fwd_we;
  logic [4:0]  mem_fwd_waddr;
  logic [31:0] mem_fwd_wdata;
  logic        mem_fwd_busy;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .ex_to_mem_valid(ex_to_mem_valid), .mem_allow_in(mem_allow_in),
    .ex_pc(ex_pc), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_alu_result(ex_alu_result), .ex_load_op(ex_load_op),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .to_wb_valid(to_wb_valid), .wb_allow_in(wb_allow_in),
    .wb_pc(wb_pc), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
    .wb_rf_wdata(wb_rf_wdata),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_waddr(mem_fwd_waddr),
    .mem_fwd_wdata(mem_fwd_wdata), .mem_fwd_busy(mem_fwd_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] alu;
    logic [2:0]  op;
    bit          got;
    logic [31:0] data;
  } ins_t;

  ins_t q[$];     // instruction currently owned by MEM (at most one)
  ins_t cur;      // instruction EX is offering
  bit   cur_v;
  int   n_pass = 0;
  int   n_tot  = 0;

  function automatic bit is_ld(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd5);
  endfunction

  // Reference load extraction by shifting and integer sign extension.
  function automatic logic [31:0] ref_align(input logic [2:0] op, input logic [1:0] off,
                                            input logic [31:0] w);
    logic [31:0] sh;
    int v;
    case (op)
      3'd1, 3'd4: begin
        sh = w >> (8 * int'(off));
        v  = int'(sh[7:0]);
        if (op == 3'd1 && v >= 128) v -= 256;
        return 32'(v);
      end
      3'd2, 3'd5: begin
        sh = w >> (16 * int'(off[1]));
        v  = int'(sh[15:0]);
        if (op == 3'd2 && v >= 32768) v -= 65536;
        return 32'(v);
      end
      default: return w;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

  // Monitor: samples mid-cycle, compares against the model, retires on handshake.
  initial begin
    ins_t h;
    bit occ, ld, rdy, fw;
    logic [31:0] ew;
    forever begin
      @(negedge clk); #3;
      if (reset) q.delete();
      else begin
        occ = (q.size() != 0);
        if (occ) h = q[0];
        ld  = occ && is_ld(h.op);
        rdy = occ && (!ld || h.got || data_sram_data_ok);
        fw  = occ && h.we && (h.wa != 5'd0);
        chk1("to_wb_valid", to_wb_valid, rdy);
        chk1("mem_allow_in", mem_allow_in, !occ || (rdy && wb_allow_in));
        chk1("mem_fwd_we", mem_fwd_we, fw);
        chk1("mem_fwd_busy", mem_fwd_busy, fw && ld && !rdy);
        if (rdy) begin
          ew = ld ? ref_align(h.op, h.alu[1:0], h.got ? h.data : data_sram_rdata) : h.alu;
          chk("wb_pc", wb_pc, h.pc);
          chk("wb_rf_we", 32'(wb_rf_we), h.we ? 32'hF : 32'h0);
          chk("wb_rf_waddr", 32'(wb_rf_waddr), 32'(h.wa));
          chk("wb_rf_wdata", wb_rf_wdata, ew);
          if (fw) chk("mem_fwd_wdata", mem_fwd_wdata, ew);
          if (wb_allow_in) void'(q.pop_front());
          else if (ld && !h.got && data_sram_data_ok) begin
            h.got  = 1'b1;
            h.data = data_sram_rdata;
            q[0]   = h;
          end
        end
      end
    end
  end

  task automatic offer(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                       input logic [31:0] alu, input logic [2:0] op);
    cur.pc = pc; cur.we = we; cur.wa = wa; cur.alu = alu; cur.op = op;
    cur.got = 1'b0; cur.data = '0;
    cur_v = 1'b1;
  endtask

  // One clock of stimulus; returns mid-cycle so callers can spot-check outputs.
  task automatic cycle(input bit dok, input logic [31:0] rd, input bit wbal);
    @(negedge clk); #1;
    ex_to_mem_valid   = cur_v;
    ex_pc             = cur.pc;
    ex_rf_we          = cur.we;
    ex_rf_waddr       = cur.wa;
    ex_alu_result     = cur.alu;
    ex_load_op        = cur.op;
    data_sram_data_ok = dok;
    data_sram_rdata   = rd;
    wb_allow_in       = wbal;
    #3;
    if (cur_v && mem_allow_in && !reset) begin
      q.push_back(cur);
      cur_v = 1'b0;
    end
  endtask

  logic [2:0]  tbl_op[3]  = '{3'd5, 3'd2, 3'd3};
  logic [31:0] tbl_exp[3] = '{32'h0000_ABCD, 32'hFFFF_ABCD, 32'hABCD_0000};

  initial begin
    reset = 1'b1; cur_v = 1'b0; cur = '{default: '0};
    ex_to_mem_valid = 0; ex_pc = 0; ex_rf_we = 0; ex_rf_waddr = 0;
    ex_alu_result = 0; ex_load_op = 0; data_sram_data_ok = 0;
    data_sram_rdata = 0; wb_allow_in = 0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    #3;
    chk1("rst to_wb_valid", to_wb_valid, 1'b0);
    chk1("rst mem_allow_in", mem_allow_in, 1'b1);
    chk("rst wb_rf_we", 32'(wb_rf_we), 32'h0);
    chk("rst wb_pc", wb_pc, 32'h0);
    chk("rst wb_rf_wdata", wb_rf_wdata, 32'h0);

    // Non-load passes straight through.
    offer(32'h100, 1'b1, 5'd5, 32'h1234_5678, 3'd0);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk("alu wdata", wb_rf_wdata, 32'h1234_5678);
    chk("alu waddr", 32'(wb_rf_waddr), 32'd5);

    // LD.B at offset 1, data two cycles after entry.
    offer(32'h104, 1'b1, 5'd7, 32'h0000_1001, 3'd1);
    cycle(0, 0, 1);
    repeat (2) begin
      cycle(0, 0, 1);
      chk1("ldb busy", mem_fwd_busy, 1'b1);
      chk1("ldb allow", mem_allow_in, 1'b0);
    end
    cycle(1, 32'h0000_8000, 1);
    chk("ldb wdata", wb_rf_wdata, 32'hFFFF_FF80);

    // Half/word extraction at offset 2.
    for (int i = 0; i < 3; i++) begin
      offer(32'h200 + 32'(4 * i), 1'b1, 5'd3, 32'h0000_2002, tbl_op[i]);
      cycle(0, 0, 1);
      cycle(1, 32'hABCD_0000, 1);
      chk("half/word wdata", wb_rf_wdata, tbl_exp[i]);
    end

    // Buffered load survives a changing bus while WB stalls.
    offer(32'h300, 1'b1, 5'd9, 32'h0000_3000, 3'd3);
    cycle(0, 0, 1);
    cycle(1, 32'h1234_5678, 0);
    repeat (3) cycle(1, 32'hDEAD_BEEF, 0);
    cycle(0, 32'hDEAD_BEEF, 1);
    chk("buffered wdata", wb_rf_wdata, 32'h1234_5678);
    offer(32'h304, 1'b1, 5'd9, 32'h0000_3004, 3'd3);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk1("got cleared", to_wb_valid, 1'b0);
    cycle(1, 32'hDEAD_BEEF, 1);

    // Back-to-back non-loads behind a stalled WB.
    offer(32'h400, 1'b1, 5'd1, 32'h11, 3'd0);
    cycle(0, 0, 0);
    offer(32'h404, 1'b1, 5'd2, 32'h22, 3'd0);
    cycle(0, 0, 0);
    chk1("b2b hold", mem_allow_in, 1'b0);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    chk("b2b pc0", wb_pc, 32'h400);
    cycle(0, 0, 1);
    chk("b2b pc1", wb_pc, 32'h404);

    // Reset during WAIT, then a late data_ok.
    offer(32'h500, 1'b1, 5'd4, 32'h0000_5000, 3'd3);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    @(negedge clk); #1;
    reset = 1'b1; ex_to_mem_valid = 1'b0; data_sram_data_ok = 1'b0; cur_v = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D; wb_allow_in = 1'b1;
    #3;
    chk1("post-rst valid", to_wb_valid, 1'b0);
    chk1("post-rst allow", mem_allow_in, 1'b1);
    chk("post-rst we", 32'(wb_rf_we), 32'h0);
    offer(32'h600, 1'b1, 5'd0, 32'h66, 3'd0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk1("waddr0 fwd_we", mem_fwd_we, 1'b0);
    cycle(0, 0, 1);

    // Randomized traffic, including op codes 6/7 and waddr 0.
    repeat (3000) begin
      if (!cur_v && $urandom_range(0, 3) != 0)
        offer($urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              $urandom, 3'($urandom_range(0, 7)));
      cycle($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 3) != 0);
    end
    cur_v = 1'b0;
    repeat (4) cycle(1, $urandom, 1);
    chk("drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. It is the upstream (sending) end of the MEM->WB valid/allow_in handshake.
- Holds one instruction from EX and waits for the data SRAM response on loads. It aligns and extends load data, then presents the register-file write bundle to WB.
- Also exports MEM-stage forwarding/hazard info to ID.

Parameters:
- ADDR_W, 5, GR index width.
- DATA_W, 32, datapath width.

Ports:
- clk  in  1  clock.
- reset  in  1  sync, active-high.
- ex_to_mem_valid  in  1  EX holds a valid instruction for MEM.
- mem_allow_in  out  1  MEM can accept this cycle.
- ex_pc  in  32  instruction PC.
- ex_rf_we  in  1  instruction writes a GR.
- ex_rf_waddr  in  5  destination GR.
- ex_alu_result  in  32  ALU result / load address.
- ex_load_op  in  3  0 none, 1 LD.B, 2 LD.H, 3 LD.W, 4 LD.BU, 5 LD.HU; 6/7 treated as none.
- data_sram_data_ok  in  1  load data valid this cycle.
- data_sram_rdata  in  32  load data.
- to_wb_valid  out  1  WB bundle valid.
- wb_allow_in  in  1  WB accepts.
- wb_pc  out  32
- wb_rf_we  out  4  4'b1111 = write, 4'b0000 = none.
- wb_rf_waddr  out  5
- wb_rf_wdata  out  32
- mem_fwd_we  out  1  MEM holds a GR writer with waddr != 0.
- mem_fwd_waddr  out  5
- mem_fwd_wdata  out  32  valid only when mem_fwd_busy = 0.
- mem_fwd_busy  out  1  MEM holds a load whose data has not arrived.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- State is derived from mem_valid, is_load and data_got:
  - IDLE: mem_valid = 0.
  - WAIT: valid load, no data yet.
  - READY: valid non-load, or valid load with data in hand.
- mem_ready_go = !is_load | data_got | data_sram_data_ok.
- to_wb_valid = mem_valid & mem_ready_go.
- mem_allow_in = !mem_valid | (mem_ready_go & wb_allow_in). Purely combinational; no added latency.
- mem_valid <= ex_to_mem_valid whenever mem_allow_in = 1.
- Payload registers (pc, rf_we, waddr, alu_result, load_op) load only when ex_to_mem_valid & mem_allow_in.
- Non-load instruction: READY in the cycle it enters. Leaves on the first cycle with wb_allow_in = 1.
- Load instruction:
  - WAIT until data_sram_data_ok.
  - If data_ok and wb_allow_in arrive in the same cycle, forward data_sram_rdata directly (zero-bubble).
  - If data_ok arrives and wb_allow_in = 0: latch rdata into rdata_buf and set data_got. The stage stays READY and uses rdata_buf.
  - Clear data_got on stage advance (mem_allow_in = 1).
- data_ok while IDLE, or while holding a non-load or a load with data_got = 1: ignore it. No state change.
- Load alignment (off = alu_result[1:0]):
  - LD.B / LD.BU: byte[off], sign- or zero-extended.
  - LD.H / LD.HU: half[off[1]], sign- or zero-extended; off[0] ignored because alignment is guaranteed upstream.
  - LD.W: full word; off ignored.
- wb_rf_wdata = aligned load data if is_load, else alu_result.
- wb_rf_we = {4{mem_valid & rf_we}}.
- wb_rf_waddr and wb_pc come from the payload registers.
- Outputs are valid only when to_wb_valid = 1.
- Forwarding:
  - mem_fwd_we = mem_valid & rf_we & (waddr != 0).
  - mem_fwd_wdata = wb_rf_wdata.
  - mem_fwd_busy = mem_fwd_we & is_load & !mem_ready_go.
- Reset values: mem_valid 0, data_got 0, rdata_buf 0, all payload registers 0. Hence to_wb_valid 0, mem_allow_in 1, wb_rf_we 0, wb_* 0, mem_fwd_we 0, mem_fwd_busy 0.
- Reset mid-load: the instruction is dropped. A data_ok arriving after reset hits IDLE and is ignored.
- Simultaneous advance and new entry: the new payload overwrites in the same edge, and data_got is cleared.

Decomposition:
- Shared package holds:
  - LOAD_OP encodings (LD_NONE, LD_B, LD_H, LD_W, LD_BU, LD_HU).
  - RF_WE_ALL = 4'b1111.
  - DATA_W / ADDR_W constants.
- One sub-module: mem_load_align. Combinational; inputs rdata, off, load_op; output aligned/extended word.
- Handshake and buffering logic stays in mem_stage.

Test Plan:
- Non-load: ALU 0x1234_5678, waddr 5, wb_allow_in = 1. -> Next cycle to_wb_valid = 1, wb_rf_we 4'b1111, wdata 0x1234_5678, waddr 5. mem_allow_in stays 1 each cycle.
- LD.B with addr ...01, rdata 0x0000_8000, data_ok 2 cycles after entry. -> mem_fwd_busy = 1 and to_wb_valid = 0 for 2 cycles. Then to_wb_valid = 1, wdata 0xFFFF_FF80. mem_allow_in = 0 while waiting.
- LD.HU with addr ...10, rdata 0xABCD_0000. -> wdata 0x0000_ABCD. The same address with LD.H gives 0xFFFF_ABCD. LD.W gives 0xABCD_0000.
- Load with data_ok while wb_allow_in = 0 for 3 cycles, rdata then changing to 0xDEAD_BEEF. -> Buffered word is delivered unchanged when wb_allow_in rises. data_got clears after advance.
- Back-to-back non-loads, wb_allow_in held 0 for 2 cycles. -> The second instruction is held in EX (mem_allow_in = 0). No loss or duplication; wb_pc sequence matches.
- Reset asserted during WAIT, then data_ok the following cycle. -> to_wb_valid = 0, mem_allow_in = 1, no write emitted. Instruction with waddr 0 gives mem_fwd_we = 0.
